// File: rtl/multi_edge_detector_pkg.sv
// Shared types and sizing helpers for the multi-channel edge detector.
package multi_edge_detector_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Filter counter must hold 0..cycles-1 and never collapse to zero width.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/edge_detect_channel.sv
// One channel: synchroniser, debounce filter, edge pulses and sticky status flag.
module edge_detect_channel
  import multi_edge_detector_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       edge_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       status_o
);

  localparam int unsigned CntW = cnt_width(FILTER_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   level_q, level_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   upd;
  logic                   rise_en, fall_en;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   edge_q, edge_d;
  logic                   status_q, status_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    upd     = 1'b0;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync;
      cnt_d   = '0;
      upd     = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    rise_en = 1'b0;
    fall_en = 1'b0;
    unique case (edge_mode_e'(mode_i))
      EDGE_OFF:  ;
      EDGE_RISE: rise_en = 1'b1;
      EDGE_FALL: fall_en = 1'b1;
      EDGE_BOTH: begin
        rise_en = 1'b1;
        fall_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Status set takes priority over a coincident clear.
  always_comb begin
    rise_d   = upd & sync;
    fall_d   = upd & ~sync;
    edge_d   = (rise_d & rise_en) | (fall_d & fall_en);
    status_d = (status_q & ~clr_i) | edge_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      edge_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din_i};
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      edge_q   <= edge_d;
      status_q <= status_d;
    end
  end

  assign level_o  = level_q;
  assign edge_o   = edge_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign status_o = status_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel synchronised, debounced edge detector with sticky status and a shared interrupt.
module multi_edge_detector
  import multi_edge_detector_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   din_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   irq_en_i,
  input  logic [NUM_CH-1:0]   clr_i,
  output logic [NUM_CH-1:0]   level_o,
  output logic [NUM_CH-1:0]   edge_o,
  output logic [NUM_CH-1:0]   rise_o,
  output logic [NUM_CH-1:0]   fall_o,
  output logic [NUM_CH-1:0]   status_o,
  output logic                irq_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    edge_detect_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .din_i   (din_i[c]),
      .mode_i  (mode_i[2*c +: 2]),
      .clr_i   (clr_i[c]),
      .level_o (level_o[c]),
      .edge_o  (edge_o[c]),
      .rise_o  (rise_o[c]),
      .fall_o  (fall_o[c]),
      .status_o(status_o[c])
    );
  end

  // Enable is combinational so software can mask/unmask without waiting a cycle.
  assign irq_o = |(status_o & irq_en_i);

endmodule
